// File: rtl/mux.sv
// mux: WIDTH-bit 2:1 select, registered or combinational, with a valid bit alongside the data
module mux #(
  parameter int WIDTH = 1,
  parameter bit REG_OUT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             sel,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);
  logic [WIDTH-1:0] pick;
  assign pick = sel ? in1 : in0;
  if (REG_OUT) begin : g_reg
    // load every cycle regardless of in_valid; reset clears data and valid
    always_ff @(posedge clk) begin
      out       <= rst ? '0 : pick;
      out_valid <= rst ? 1'b0 : in_valid;
    end
  end else begin : g_comb
    // zero-latency pass-through; valid is suppressed while reset is held
    always_comb begin
      out       = pick;
      out_valid = in_valid & ~rst;
    end
  end
endmodule

// File: tb/tb_mux.sv
// tb_mux: randomized and directed checks of registered and combinational mux variants
module tb_mux;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0] a4_0, a4_1, o4;
  logic       s4, v4, ov4;
  logic [0:0] a1_0, a1_1, o1;
  logic       s1, v1, ov1;
  logic [7:0] a8_0, a8_1, o8;
  logic       s8, v8, ov8;
  logic [3:0] ac_0, ac_1, oc;
  logic       sc, vc, ovc;

  int n_checks = 0;
  int n_fail = 0;

  mux #(.WIDTH(4), .REG_OUT(1)) u4 (.clk(clk), .rst(rst), .in0(a4_0), .in1(a4_1), .sel(s4),
    .in_valid(v4), .out(o4), .out_valid(ov4));
  mux #(.WIDTH(1), .REG_OUT(1)) u1 (.clk(clk), .rst(rst), .in0(a1_0), .in1(a1_1), .sel(s1),
    .in_valid(v1), .out(o1), .out_valid(ov1));
  mux #(.WIDTH(8), .REG_OUT(1)) u8 (.clk(clk), .rst(rst), .in0(a8_0), .in1(a8_1), .sel(s8),
    .in_valid(v8), .out(o8), .out_valid(ov8));
  mux #(.WIDTH(4), .REG_OUT(0)) uc (.clk(clk), .rst(rst), .in0(ac_0), .in1(ac_1), .sel(sc),
    .in_valid(vc), .out(oc), .out_valid(ovc));

  function automatic logic [63:0] model(logic [63:0] a, logic [63:0] b, logic s);
    logic [63:0] choices [2];
    choices[0] = a;
    choices[1] = b;
    return choices[s];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a4_0 = 4'hF; a4_1 = 4'hA; s4 = 1'b1; v4 = 1'b1;
    a1_0 = 1'b1; a1_1 = 1'b1; s1 = 1'b0; v1 = 1'b1;
    a8_0 = 8'hFF; a8_1 = 8'hFF; s8 = 1'b1; v8 = 1'b1;
    ac_0 = 4'h1; ac_1 = 4'h8; sc = 1'b0; vc = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (o4 !== 4'h0 || ov4 !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_u4 cycle %0d: got out=%h valid=%b want out=0 valid=0", i, o4, ov4);
      end
      n_checks++;
      if (o1 !== 1'b0 || ov1 !== 1'b0 || o8 !== 8'h00 || ov8 !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_u1_u8 cycle %0d: got o1=%b v1=%b o8=%h v8=%b want all 0", i, o1, ov1, o8, ov8);
      end
      n_checks++;
      if (ovc !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_comb_valid: got %b want 0", ovc);
      end
    end
    rst = 1'b0;
    v1 = 1'b0; v8 = 1'b0;
    tick();
    n_checks++;
    if (o4 !== 4'hA || ov4 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: got out=%h valid=%b want out=a valid=1", o4, ov4);
    end
  endtask

  task automatic test_select();
    a4_0 = 4'h3; a4_1 = 4'hC; v4 = 1'b1;
    s4 = 1'b0;
    tick();
    n_checks++;
    if (o4 !== 4'h3) begin
      n_fail++;
      $display("FAIL select_0: got %h want 3", o4);
    end
    s4 = 1'b1;
    tick();
    n_checks++;
    if (o4 !== 4'hC) begin
      n_fail++;
      $display("FAIL select_1: got %h want c", o4);
    end
  endtask

  task automatic test_exhaustive_1bit();
    logic [2:0] c;
    logic       e;
    for (int i = 0; i < 8; i++) begin
      c = 3'(i);
      a1_0 = c[0]; a1_1 = c[1]; s1 = c[2]; v1 = 1'b1;
      e = model(64'(c[0]), 64'(c[1]), c[2]) != 0;
      tick();
      n_checks++;
      if (o1 !== e || ov1 !== 1'b1) begin
        n_fail++;
        $display("FAIL exhaustive_1bit in0=%b in1=%b sel=%b: got %b/%b want %b/1", c[0], c[1], c[2], o1, ov1, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    a8_0 = 8'h55; a8_1 = 8'hAA; v8 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s8 = 1'(i % 2);
      e = (i % 2 == 1) ? 8'hAA : 8'h55;
      tick();
      n_checks++;
      if (o8 !== e || ov8 !== 1'b1) begin
        n_fail++;
        $display("FAIL back_to_back step %0d: got %h/%b want %h/1", i, o8, ov8, e);
      end
    end
  endtask

  task automatic test_valid();
    logic pat [3] = '{1'b1, 1'b0, 1'b1};
    a4_0 = 4'h6; a4_1 = 4'h9; s4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      v4 = pat[i];
      tick();
      n_checks++;
      if (ov4 !== pat[i] || o4 !== 4'h6) begin
        n_fail++;
        $display("FAIL valid_track step %0d: got %h/%b want 6/%b", i, o4, ov4, pat[i]);
      end
    end
    v4 = 1'b1; s4 = 1'b1; rst = 1'b1;
    tick();
    n_checks++;
    if (o4 !== 4'h0 || ov4 !== 1'b0) begin
      n_fail++;
      $display("FAIL valid_midreset: got %h/%b want 0/0", o4, ov4);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (o4 !== 4'h9 || ov4 !== 1'b1) begin
      n_fail++;
      $display("FAIL valid_after_reset: got %h/%b want 9/1", o4, ov4);
    end
  endtask

  task automatic test_comb();
    ac_0 = 4'h1; ac_1 = 4'h8; vc = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sc = 1'(i % 2);
      #1;
      n_checks++;
      if (oc !== ((i % 2 == 1) ? 4'h8 : 4'h1) || ovc !== 1'b1) begin
        n_fail++;
        $display("FAIL comb_select step %0d: got %h/%b want %h/1", i, oc, ovc, (i % 2 == 1) ? 4'h8 : 4'h1);
      end
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (ovc !== 1'b0 || oc !== 4'h8) begin
      n_fail++;
      $display("FAIL comb_reset: got %h/%b want 8/0", oc, ovc);
    end
    rst = 1'b0;
    vc = 1'b0;
    #1;
    n_checks++;
    if (ovc !== 1'b0) begin
      n_fail++;
      $display("FAIL comb_invalid: got %b want 0", ovc);
    end
    tick();
  endtask

  task automatic test_random();
    logic [7:0] e8;
    logic [3:0] ec;
    logic       ev8, evc;
    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(0, 15) == 0);
      a8_0 = 8'($urandom); a8_1 = 8'($urandom); s8 = 1'($urandom); v8 = 1'($urandom);
      ac_0 = 4'($urandom); ac_1 = 4'($urandom); sc = 1'($urandom); vc = 1'($urandom);
      e8 = rst ? 8'h00 : 8'(model(64'(a8_0), 64'(a8_1), s8));
      ev8 = rst ? 1'b0 : v8;
      ec = 4'(model(64'(ac_0), 64'(ac_1), sc));
      evc = rst ? 1'b0 : vc;
      #1;
      n_checks++;
      if (oc !== ec || ovc !== evc) begin
        n_fail++;
        $display("FAIL random_comb %0d: got %h/%b want %h/%b", i, oc, ovc, ec, evc);
      end
      tick();
      n_checks++;
      if (o8 !== e8 || ov8 !== ev8) begin
        n_fail++;
        $display("FAIL random_reg %0d: got %h/%b want %h/%b", i, o8, ov8, e8, ev8);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_select();
    test_exhaustive_1bit();
    test_back_to_back();
    test_valid();
    test_comb();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
